// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage with stall counter and synchronous flush.
// Define PIPE_STAGE_BUF_SKID_EN for the registered-ready skid variant.
module pipe_stage_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } state_t;

  state_t state;
  logic   in_xfer;
  logic   out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_STAGE_BUF_SKID_EN

  logic [WIDTH-1:0] skid;

  // in_ready tracks "next state is not TWO"
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      in_ready <= 1'b1;
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            state     <= ONE;
            out_valid <= 1'b1;
            out_data  <= in_data;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_data <= in_data;
          end else if (in_xfer) begin
            state    <= TWO;
            skid     <= in_data;
            in_ready <= 1'b0;
          end else if (out_xfer) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        TWO: begin
          if (out_xfer) begin
            state    <= ONE;
            out_data <= skid;
          end else begin
            in_ready <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`else

  // live keeps in_ready low until the first edge after reset
  logic live;

  assign in_ready = live && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      live      <= 1'b0;
    end else begin
      live <= 1'b1;
      if (flush) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end else begin
        unique case (state)
          EMPTY: begin
            if (in_xfer) begin
              state     <= ONE;
              out_valid <= 1'b1;
              out_data  <= in_data;
            end
          end
          ONE: begin
            if (in_xfer) begin
              out_data <= in_data;
            end else if (out_xfer) begin
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

`endif

endmodule
